// File: rtl/amm_copy_master.sv
// Avalon-MM DMA copy engine: reads words from the source region, buffers them in a small FIFO, writes them to the destination.
// Define AMM_COPY_CHECKSUM_EN to build a running sum of written words on status_checksum (tied to 0 otherwise).
module amm_copy_master #(
   parameter int MASTER_ADDRESSWIDTH = 26,
   parameter int DATAWIDTH           = 32,
   parameter int LENWIDTH            = 16,
   parameter int FIFO_DEPTH          = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cmd_start,
   input  logic [MASTER_ADDRESSWIDTH-1:0] cmd_src_addr,
   input  logic [MASTER_ADDRESSWIDTH-1:0] cmd_dst_addr,
   input  logic [LENWIDTH-1:0]            cmd_len_words,
   output logic                           status_busy,
   output logic                           status_done,
   output logic [LENWIDTH-1:0]            status_words_done,
   output logic [DATAWIDTH-1:0]           status_checksum,
   output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
   output logic                           master_read,
   output logic                           master_write,
   output logic [DATAWIDTH-1:0]           master_writedata,
   input  logic [DATAWIDTH-1:0]           master_readdata,
   input  logic                           master_readdatavalid,
   input  logic                           master_waitrequest
);
   localparam int AW = MASTER_ADDRESSWIDTH;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [AW-1:0]          src_reg, src_next, dst_reg, dst_next, address_reg, address_next;
   logic [LENWIDTH-1:0]    len_reg, len_next, reads_left_reg, reads_left_next;
   logic [LENWIDTH-1:0]    words_done_reg, words_done_next;
   logic [CW-1:0]          outstanding_reg, outstanding_next, count_reg, count_next;
   logic [PW-1:0]          wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
   logic                   read_reg, read_next, write_reg, write_next, done_reg, done_next;
   logic [DATAWIDTH-1:0]   writedata_reg, writedata_next;
   logic [DATAWIDTH-1:0]   fifo_mem [FIFO_DEPTH];
   logic                   push, pop, read_accept, accept;

   always_comb begin
      state_next      = state_reg;
      src_next        = src_reg;
      dst_next        = dst_reg;
      address_next    = address_reg;
      len_next        = len_reg;
      reads_left_next = reads_left_reg;
      words_done_next = words_done_reg;
      read_next       = read_reg;
      write_next      = write_reg;
      done_next       = done_reg;
      writedata_next  = writedata_reg;
      push            = 1'b0;
      pop             = 1'b0;
      read_accept     = 1'b0;
      accept          = (read_reg || write_reg) && !master_waitrequest;
      case (state_reg)
         IDLE: begin
            if (cmd_start) begin
               src_next        = cmd_src_addr;
               dst_next        = cmd_dst_addr;
               len_next        = cmd_len_words;
               reads_left_next = cmd_len_words;
               words_done_next = '0;
               done_next       = (cmd_len_words == '0);
               state_next      = (cmd_len_words == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            push = master_readdatavalid;
            if (read_reg || write_reg) begin
               // a pending command is held untouched until the slave takes it
               if (accept) begin
                  read_next  = 1'b0;
                  write_next = 1'b0;
                  if (read_reg) begin
                     read_accept     = 1'b1;
                     src_next        = src_reg + AW'(4);
                     reads_left_next = reads_left_reg - LENWIDTH'(1);
                  end else begin
                     pop             = 1'b1;
                     dst_next        = dst_reg + AW'(4);
                     words_done_next = words_done_reg + LENWIDTH'(1);
                  end
               end
            end else if (words_done_reg == len_reg) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else if (count_reg != '0) begin
               write_next     = 1'b1;
               address_next   = dst_reg;
               writedata_next = fifo_mem[rd_ptr_reg];
            end else if (reads_left_reg != '0 &&
                         (outstanding_reg + count_reg) < CW'(FIFO_DEPTH)) begin
               read_next    = 1'b1;
               address_next = src_reg;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      outstanding_next = outstanding_reg + CW'(read_accept) - CW'(push);
      count_next       = count_reg + CW'(push) - CW'(pop);
      wr_ptr_next      = wr_ptr_reg + PW'(push);
      rd_ptr_next      = rd_ptr_reg + PW'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         src_reg         <= '0;
         dst_reg         <= '0;
         address_reg     <= '0;
         len_reg         <= '0;
         reads_left_reg  <= '0;
         words_done_reg  <= '0;
         outstanding_reg <= '0;
         count_reg       <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         read_reg        <= 1'b0;
         write_reg       <= 1'b0;
         done_reg        <= 1'b0;
         writedata_reg   <= '0;
      end else begin
         state_reg       <= state_next;
         src_reg         <= src_next;
         dst_reg         <= dst_next;
         address_reg     <= address_next;
         len_reg         <= len_next;
         reads_left_reg  <= reads_left_next;
         words_done_reg  <= words_done_next;
         outstanding_reg <= outstanding_next;
         count_reg       <= count_next;
         wr_ptr_reg      <= wr_ptr_next;
         rd_ptr_reg      <= rd_ptr_next;
         read_reg        <= read_next;
         write_reg       <= write_next;
         done_reg        <= done_next;
         writedata_reg   <= writedata_next;
      end
   end

   // buffer storage carries no reset so it maps onto plain RAM
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= master_readdata;
   end

`ifdef AMM_COPY_CHECKSUM_EN
   logic [DATAWIDTH-1:0] checksum_reg;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              checksum_reg <= '0;
      else if (state_reg == IDLE && cmd_start) checksum_reg <= '0;
      else if (pop)                           checksum_reg <= checksum_reg + writedata_reg;
   end
   assign status_checksum = checksum_reg;
`else
   assign status_checksum = '0;
`endif

   assign status_busy       = (state_reg == RUN);
   assign status_done       = done_reg;
   assign status_words_done = words_done_reg;
   assign master_address    = address_reg;
   assign master_read       = read_reg;
   assign master_write      = write_reg;
   assign master_writedata  = writedata_reg;
endmodule

// File: tb/tb_amm_copy_master.sv
// Bench for amm_copy_master: Avalon slave memory model with programmable latency/stalls and a write scoreboard.
`timescale 1ns/1ps
module tb_amm_copy_master;
   localparam int AW = 26, DW = 32, LW = 16, FD = 8, NV = 7;

   typedef struct { logic [AW-1:0] src; logic [AW-1:0] dst; logic [LW-1:0] len;
                    int lat; bit stall; bit mid_start; logic [LW-1:0] exp_words; } vec_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
   typedef struct { logic [DW-1:0] data; int due; } rd_t;

   logic clk = 1'b0, reset = 1'b0, cmd_start = 1'b0;
   logic [AW-1:0] cmd_src_addr = '0, cmd_dst_addr = '0;
   logic [LW-1:0] cmd_len_words = '0;
   logic status_busy, status_done, master_read, master_write;
   logic [LW-1:0] status_words_done;
   logic [DW-1:0] status_checksum, master_writedata;
   logic [AW-1:0] master_address;
   logic [DW-1:0] master_readdata = '0;
   logic master_readdatavalid = 1'b0, master_waitrequest = 1'b0;

   always #5 clk = ~clk;

   amm_copy_master #(.MASTER_ADDRESSWIDTH(AW), .DATAWIDTH(DW), .LENWIDTH(LW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_src_addr(cmd_src_addr),
      .cmd_dst_addr(cmd_dst_addr), .cmd_len_words(cmd_len_words), .status_busy(status_busy),
      .status_done(status_done), .status_words_done(status_words_done),
      .status_checksum(status_checksum), .master_address(master_address),
      .master_read(master_read), .master_write(master_write),
      .master_writedata(master_writedata), .master_readdata(master_readdata),
      .master_readdatavalid(master_readdatavalid), .master_waitrequest(master_waitrequest));

   wr_t sb[$];
   rd_t rdq[$];
   logic [DW-1:0] mem [1024];
   int total_cnt = 0, bad_cnt = 0;
   int cyc = 0, lat = 2, rd_acc = 0, wr_acc = 0, cmd_cnt = 0, stall_left = 0, max_inflight = 0;
   bit stall_en = 0, seen = 0, busy_seen = 0, inject_stray = 0;
   logic [AW-1:0] cap_addr = '0;
   logic [DW-1:0] cap_data = '0;
   logic cap_rd = 1'b0, cap_wr = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // slave model: decides waitrequest and accepts at mid-cycle, returns read data after lat cycles
   always @(negedge clk) begin
      rd_t r;
      wr_t e;
      int inflight;
      cyc++;
      if (inject_stray) begin
         master_readdatavalid = 1'b1;
         master_readdata      = 32'hDEAD_BEEF;
         inject_stray         = 0;
      end else if (rdq.size() != 0 && rdq[0].due <= cyc) begin
         r = rdq.pop_front();
         master_readdatavalid = 1'b1;
         master_readdata      = r.data;
      end else begin
         master_readdatavalid = 1'b0;
         master_readdata      = 32'hBAD0_BAD0;
      end
      if (master_read || master_write) begin
         if (!seen) begin
            seen = 1; cmd_cnt++;
            cap_addr = master_address; cap_data = master_writedata;
            cap_rd = master_read; cap_wr = master_write;
            stall_left = (stall_en && ((master_read && rd_acc == 1) ||
                                       (master_write && wr_acc == 0))) ? 3 : 0;
         end else begin
            chk("stall_addr", 64'(master_address), 64'(cap_addr));
            chk("stall_rd", 64'(master_read), 64'(cap_rd));
            chk("stall_wr", 64'(master_write), 64'(cap_wr));
            if (cap_wr) chk("stall_data", 64'(master_writedata), 64'(cap_data));
         end
         if (stall_left > 0) begin
            master_waitrequest = 1'b1;
            stall_left--;
         end else begin
            master_waitrequest = 1'b0;
            seen = 0;
            if (master_read) begin
               rdq.push_back('{mem[master_address[11:2]], cyc + lat});
               rd_acc++;
            end else begin
               wr_acc++;
               if (sb.size() == 0) begin
                  total_cnt++; bad_cnt++;
                  $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want none",
                           master_address, master_writedata);
               end else begin
                  e = sb.pop_front();
                  chk("wr_addr", 64'(master_address), 64'(e.addr));
                  chk("wr_data", 64'(master_writedata), 64'(e.data));
               end
               mem[master_address[11:2]] = master_writedata;
            end
         end
      end else begin
         master_waitrequest = 1'b0;
         seen = 0;
      end
      inflight = rd_acc - wr_acc + ((master_read && master_waitrequest) ? 1 : 0);
      if (inflight > max_inflight) max_inflight = inflight;
      if (status_busy) busy_seen = 1;
   end

   task automatic run_copy(input vec_t v);
      logic [DW-1:0] exp_sum = '0;
      logic [AW-1:0] a;
      int n = int'(v.len);
      int k;
      rd_acc = 0; wr_acc = 0; cmd_cnt = 0; max_inflight = 0; busy_seen = 0;
      lat = v.lat; stall_en = v.stall;
      for (int i = 0; i < n; i++) begin
         a = v.src + AW'(4 * i);
         sb.push_back('{v.dst + AW'(4 * i), mem[a[11:2]]});
         exp_sum += mem[a[11:2]];
      end
      @(negedge clk);
      cmd_src_addr = v.src; cmd_dst_addr = v.dst; cmd_len_words = v.len; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("first_cmd_early", 64'(master_read | master_write), 64'd0);
      chk("busy_after_start", 64'(status_busy), 64'(v.len != 0));
      if (v.len != 0) chk("done_cleared", 64'(status_done), 64'd0);
      @(negedge clk);
      if (v.len != 0) chk("first_cmd_read", 64'(master_read), 64'd1);
      else            chk("zero_len_done", 64'(status_done), 64'd1);
      for (k = 0; k < 3000 && !status_done; k++) begin
         @(negedge clk);
         if (v.mid_start && k == 5) begin
            cmd_src_addr = 26'h3000; cmd_dst_addr = 26'h3400; cmd_len_words = 16'd3;
            cmd_start = 1'b1;
         end else cmd_start = 1'b0;
      end
      cmd_start = 1'b0;
      repeat (4) @(negedge clk);
      $display("copy src=0x%0h dst=0x%0h len=%0d lat=%0d stall=%0d: words_done=%0d checksum=0x%0h max_inflight=%0d",
               v.src, v.dst, v.len, v.lat, v.stall, status_words_done, status_checksum, max_inflight);
      chk("done", 64'(status_done), 64'd1);
      chk("busy_end", 64'(status_busy), 64'd0);
      chk("words_done", 64'(status_words_done), 64'(v.exp_words));
      chk("write_count", 64'(wr_acc), 64'(n));
      chk("read_count", 64'(rd_acc), 64'(n));
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("credit", 64'(max_inflight <= FD), 64'd1);
`ifdef AMM_COPY_CHECKSUM_EN
      chk("checksum", 64'(status_checksum), 64'(exp_sum));
`else
      chk("checksum", 64'(status_checksum), 64'd0);
`endif
      if (v.len == 0) begin
         chk("zero_len_cmds", 64'(cmd_cnt), 64'd0);
         chk("zero_len_busy", 64'(busy_seen), 64'd0);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_read"}, 64'(master_read), 64'd0);
      chk({tag, "_write"}, 64'(master_write), 64'd0);
      chk({tag, "_addr"}, 64'(master_address), 64'd0);
      chk({tag, "_wdata"}, 64'(master_writedata), 64'd0);
      chk({tag, "_busy"}, 64'(status_busy), 64'd0);
      chk({tag, "_done"}, 64'(status_done), 64'd0);
      chk({tag, "_words"}, 64'(status_words_done), 64'd0);
      chk({tag, "_csum"}, 64'(status_checksum), 64'd0);
   endtask

   initial begin
      vec_t vecs[NV];
      int k;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h9E37_79B1);
      mem[64] = 32'd1; mem[65] = 32'd2; mem[66] = 32'd3; mem[67] = 32'd4;
      vecs[0] = '{26'h100,     26'h200,     16'd4,  2,  1'b0, 1'b0, 16'd4};
      vecs[1] = '{26'h300,     26'h400,     16'd6,  3,  1'b1, 1'b0, 16'd6};
      vecs[2] = '{26'h500,     26'h600,     16'd20, 10, 1'b0, 1'b1, 16'd20};
      vecs[3] = '{26'h700,     26'h780,     16'd0,  2,  1'b0, 1'b0, 16'd0};
      vecs[4] = '{26'h3FFFFF8, 26'h900,     16'd4,  1,  1'b0, 1'b0, 16'd4};
      vecs[5] = '{26'h980,     26'h3FFFFFC, 16'd3,  1,  1'b0, 1'b0, 16'd3};
      vecs[6] = '{26'hE00,     26'hF00,     16'd9,  1,  1'b1, 1'b0, 16'd9};

      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_outputs_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) run_copy(vecs[i]);

      // reset in the middle of a copy, then a stray read return, then a fresh copy
      rd_acc = 0; wr_acc = 0; lat = 4; stall_en = 0;
      for (int i = 0; i < 10; i++) sb.push_back('{26'hB00 + AW'(4 * i), mem[10'h280 + 10'(i)]});
      @(negedge clk);
      cmd_src_addr = 26'hA00; cmd_dst_addr = 26'hB00; cmd_len_words = 16'd10; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      for (k = 0; k < 500 && wr_acc < 3; k++) @(negedge clk);
      chk("pre_reset_writes", 64'(wr_acc), 64'd3);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk_outputs_zero("async_reset");
      $display("reset mid-transfer after %0d writes", wr_acc);
      sb.delete(); rdq.delete(); seen = 0; stall_left = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      cmd_cnt = 0; inject_stray = 1;
      repeat (4) @(negedge clk);
      chk("stray_busy", 64'(status_busy), 64'd0);
      chk("stray_cmds", 64'(cmd_cnt), 64'd0);
      chk("stray_words", 64'(status_words_done), 64'd0);
      run_copy('{26'hC00, 26'hD00, 16'd2, 2, 1'b0, 1'b0, 16'd2});

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end
endmodule
